// File: rtl/down_timer_pkg.sv
// Shared state encoding and default sizing for the loadable down-counter/timer.
package down_timer_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/down_timer_if.sv
// Control/status bundle between a controller (master) and the down_timer (slave).
interface down_timer_if
    import down_timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             stop;
    logic             hold;
    logic             auto_reload;
    logic [WIDTH-1:0] cnt;
    logic             busy;
    logic             done;

    modport master (
        output load, load_val, start, stop, hold, auto_reload,
        input  cnt, busy, done
    );

    modport slave (
        input  load, load_val, start, stop, hold, auto_reload,
        output cnt, busy, done
    );
endinterface

// File: rtl/down_timer.sv
// Loadable down-counter with one-shot / auto-reload modes and a registered done pulse.
// Priority at every edge: rst > load > stop > hold > start/decrement.
module down_timer
    import down_timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic        clk,
    input  logic        rst,
    down_timer_if.slave bus
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           r_state;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_reload;
    logic             r_done;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] w_reload_nxt;
    logic             w_done_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_reload <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_reload <= w_reload_nxt;
            r_done   <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_reload_nxt = r_reload;
        w_done_nxt   = 1'b0;

        if (bus.load) begin
            w_cnt_nxt    = bus.load_val;
            w_reload_nxt = bus.load_val;
            w_state_nxt  = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!bus.stop && bus.start) begin
                        if (r_cnt != '0) w_state_nxt = ST_RUN;
                        else             w_done_nxt  = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (bus.stop) begin
                        w_state_nxt = ST_IDLE;
                    end else if (bus.hold) begin
                        w_state_nxt = ST_HOLD;
                    end else if (r_cnt > ONE) begin
                        w_cnt_nxt = r_cnt - ONE;
                    end else begin
                        // Expiry; a zero reload in periodic mode also lands here,
                        // so the decrement can never wrap.
                        w_done_nxt = 1'b1;
                        if (bus.auto_reload) begin
                            w_cnt_nxt = r_reload;
                        end else begin
                            w_cnt_nxt   = '0;
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.stop)       w_state_nxt = ST_IDLE;
                    else if (!bus.hold) w_state_nxt = ST_RUN;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign bus.cnt  = r_cnt;
    assign bus.busy = (r_state != ST_IDLE);
    assign bus.done = r_done;

endmodule

// File: tb/tb_down_timer.sv
// Directed bench for down_timer: a vector table plus sequences for long/multi-cycle cases.
module tb_down_timer;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    down_timer_if #(.WIDTH(W)) bus ();

    down_timer #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic         rst, load;
        logic [W-1:0] val;
        logic         start, stop, hold, ar;
        logic [W-1:0] e_cnt;
        logic         e_busy, e_done;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic vec_t v(bit r, bit ld, int val, bit st, bit sp, bit hd, bit ar,
                               int c, bit b, bit d);
        vec_t x;
        x.rst = r; x.load = ld; x.val = W'(val); x.start = st; x.stop = sp;
        x.hold = hd; x.ar = ar; x.e_cnt = W'(c); x.e_busy = b; x.e_done = d;
        return x;
    endfunction

    task automatic drive(bit r, bit ld, int val, bit st, bit sp, bit hd, bit ar);
        rst             = r;
        bus.load        = ld;
        bus.load_val    = W'(val);
        bus.start       = st;
        bus.stop        = sp;
        bus.hold        = hd;
        bus.auto_reload = ar;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string nm, int c, bit b, bit d);
        n_checks++;
        if (bus.cnt !== W'(c) || bus.busy !== b || bus.done !== d) begin
            n_fail++;
            $display("FAIL %s: got cnt=%0d busy=%b done=%b, expected cnt=%0d busy=%b done=%b",
                     nm, bus.cnt, bus.busy, bus.done, c, b, d);
        end
    endtask

    vec_t tbl[33];

    initial begin
        int pulses;
        int done_at;

        bus.load = 0; bus.load_val = '0; bus.start = 0;
        bus.stop = 0; bus.hold = 0; bus.auto_reload = 0;

        //          rst ld val st sp hd ar   cnt busy done
        tbl[0]  = v(1, 0, 0, 0, 0, 0, 0,    0, 0, 0);  // reset state
        tbl[1]  = v(0, 1, 5, 0, 0, 0, 0,    5, 0, 0);  // load 5
        tbl[2]  = v(0, 0, 0, 1, 0, 0, 0,    5, 1, 0);  // start, no decrement yet
        tbl[3]  = v(0, 0, 0, 0, 0, 0, 0,    4, 1, 0);
        tbl[4]  = v(0, 0, 0, 0, 0, 0, 0,    3, 1, 0);
        tbl[5]  = v(0, 0, 0, 0, 0, 0, 0,    2, 1, 0);
        tbl[6]  = v(0, 0, 0, 0, 0, 0, 0,    1, 1, 0);
        tbl[7]  = v(0, 0, 0, 0, 0, 0, 0,    0, 0, 1);  // expiry: done with busy low
        tbl[8]  = v(0, 0, 0, 0, 0, 0, 0,    0, 0, 0);  // single pulse
        tbl[9]  = v(0, 0, 0, 1, 0, 0, 0,    0, 0, 1);  // zero-length timer
        tbl[10] = v(0, 0, 0, 0, 0, 0, 0,    0, 0, 0);
        tbl[11] = v(0, 1, 2, 0, 0, 0, 0,    2, 0, 0);
        tbl[12] = v(0, 0, 0, 1, 0, 0, 0,    2, 1, 0);
        tbl[13] = v(0, 0, 0, 0, 0, 0, 0,    1, 1, 0);
        tbl[14] = v(0, 0, 0, 0, 1, 0, 0,    1, 0, 0);  // stop beats expiry
        tbl[15] = v(0, 0, 0, 0, 0, 0, 0,    1, 0, 0);
        tbl[16] = v(0, 0, 0, 1, 0, 0, 0,    1, 1, 0);
        tbl[17] = v(0, 1, 7, 1, 1, 0, 0,    7, 0, 0);  // load beats start/stop
        tbl[18] = v(0, 0, 0, 1, 0, 0, 0,    7, 1, 0);
        tbl[19] = v(0, 0, 0, 0, 0, 0, 0,    6, 1, 0);
        tbl[20] = v(0, 0, 0, 0, 0, 0, 0,    5, 1, 0);
        tbl[21] = v(0, 0, 0, 0, 0, 0, 0,    4, 1, 0);
        tbl[22] = v(0, 0, 0, 0, 0, 0, 0,    3, 1, 0);
        tbl[23] = v(0, 0, 0, 0, 0, 0, 0,    2, 1, 0);
        tbl[24] = v(0, 0, 0, 0, 0, 0, 0,    1, 1, 0);
        tbl[25] = v(0, 0, 0, 0, 0, 1, 0,    1, 1, 0);  // hold beats expiry
        tbl[26] = v(0, 0, 0, 0, 0, 0, 0,    1, 1, 0);  // resume edge, no decrement
        tbl[27] = v(0, 0, 0, 0, 0, 0, 0,    0, 0, 1);
        tbl[28] = v(0, 1, 9, 0, 0, 0, 0,    9, 0, 0);
        tbl[29] = v(0, 0, 0, 1, 0, 0, 0,    9, 1, 0);
        tbl[30] = v(1, 1, 5, 1, 0, 0, 0,    0, 0, 0);  // reset mid-run overrides load
        tbl[31] = v(1, 0, 0, 0, 0, 0, 0,    0, 0, 0);
        tbl[32] = v(0, 0, 0, 1, 0, 0, 1,    0, 0, 1);  // count cleared by reset

        for (int i = 0; i < 33; i++) begin
            drive(tbl[i].rst, tbl[i].load, int'(tbl[i].val), tbl[i].start,
                  tbl[i].stop, tbl[i].hold, tbl[i].ar);
            chk($sformatf("vec%0d", i), int'(tbl[i].e_cnt), tbl[i].e_busy, tbl[i].e_done);
        end

        // Maximum count: 15 decrements, no wrap.
        drive(0, 1, 15, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0);
        chk("max_start", 15, 1, 0);
        for (int k = 1; k <= 15; k++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            chk($sformatf("max_k%0d", k), 15 - k, k < 15, k == 15);
        end

        // Periodic: 3,2,1,3,... with a done on every reload.
        drive(0, 1, 3, 0, 0, 0, 1);
        drive(0, 0, 0, 1, 0, 0, 1);
        chk("per_start", 3, 1, 0);
        pulses = 0;
        for (int k = 1; k <= 12; k++) begin
            drive(0, 0, 0, 0, 0, 0, 1);
            if (bus.done === 1'b1) pulses++;
            chk($sformatf("per_k%0d", k), (k % 3 == 0) ? 3 : 3 - (k % 3), 1, k % 3 == 0);
        end
        n_checks++;
        if (pulses != 4) begin
            n_fail++;
            $display("FAIL per_pulses: got %0d, expected 4", pulses);
        end
        drive(0, 0, 0, 0, 1, 0, 1);
        chk("per_stop", 3, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("per_idle", 3, 0, 0);

        // Hold for 3 cycles at cnt=2: done lands 4 edges later than the unheld E0+4.
        drive(0, 1, 4, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("hold_pre", 2, 1, 0);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 0, 1, 0);
            chk($sformatf("hold_h%0d", k), 2, 1, 0);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("hold_resume", 2, 1, 0);
        done_at = -1;
        for (int k = 1; k <= 20 && done_at < 0; k++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            if (bus.done === 1'b1) done_at = k;
        end
        n_checks++;
        if (done_at != 2) begin
            n_fail++;
            $display("FAIL hold_done_edge: got %0d edges after resume, expected 2", done_at);
        end
        chk("hold_done", 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/down_timer.md
Name: down_timer

Overview:
- Loadable down-counter/timer. It is the count-down counterpart of the existing free-running 4-bit up-counter.
- Software or an FSM loads a terminal value, starts the timer, and receives a one-cycle done pulse when the count expires.
- Optional auto-reload turns it into a periodic tick generator for slower blocks.
- Sits beside the up-counter in the digital_logic_circuit lab set; it shares its clock domain.

Parameters:
- WIDTH, 4, bit width of count, load value and reload register.

Ports:
- clk  input  1  system clock; rising-edge active.
- rst  input  1  reset; synchronous and active-high. One clock; all state is updated only on the rising edge of clk.
- load  input  1  load request; captures load_val into the count and the reload register.
- load_val  input  WIDTH  value captured on load.
- start  input  1  begin counting from the current count (IDLE only).
- stop  input  1  abort counting; count is retained.
- hold  input  1  freeze count while asserted (RUN/HOLD only).
- auto_reload  input  1  1 = periodic mode, 0 = one-shot; sampled each cycle.
- cnt  output  WIDTH  current count (registered).
- busy  output  1  high in RUN or HOLD.
- done  output  1  one-cycle pulse on expiry (registered).

Behaviour:
- Reset (rst=1 at an edge): cnt=0, reload_reg=0, busy=0, done=0, state=IDLE. Reset overrides all inputs.
- States: IDLE, RUN, HOLD. busy = (state != IDLE), decoded from registered state.
- Priority at any edge: rst > load > stop > hold > start/decrement.
- done defaults to 0 every edge; it is only set by the expiry rules below.
- load (any state): cnt<=load_val, reload_reg<=load_val, next state IDLE. This aborts a running count, and no done is generated.
- stop in RUN/HOLD: next IDLE, cnt unchanged, done=0. stop in IDLE: no effect.
- IDLE + start, cnt!=0: next RUN, cnt unchanged on this edge.
- IDLE + start, cnt==0: zero-length timer. done=1 for the next cycle, state stays IDLE.
- IDLE, no start: all registers hold.
- RUN, hold=1: next HOLD, cnt unchanged.
- HOLD, hold=1: stay HOLD, cnt unchanged. HOLD, hold=0: next RUN, no decrement on that edge.
- RUN, hold=0, cnt>1: cnt<=cnt-1.
- RUN, hold=0, cnt==1, auto_reload=0: cnt<=0, done<=1, next IDLE.
- RUN, hold=0, cnt==1, auto_reload=1: cnt<=reload_reg, done<=1, stay RUN. cnt never shows 0 in this mode.
- Latency:
  - One-shot, loaded N>0, start sampled at edge E0: RUN from E0. done high in the cycle after edge E0+N, with cnt=0 and busy=0 in that same cycle.
  - Periodic: done pulses every N cycles (each hold cycle adds one).
- Arithmetic: unsigned, WIDTH bits. Decrement never underflows, because cnt==0 is not reachable in RUN.
- Maximum count: load_val=2^WIDTH-1 gives 15 cycles at WIDTH=4.
- Simultaneous events:
  - load+start: load wins and start is ignored.
  - stop+expiry in the same cycle: stop wins, so done=0 and cnt stays 1.
  - hold+expiry: hold wins, so there is no done.
- Reset mid-count: next cycle cnt=0, busy=0, done=0; reload_reg is cleared.

Decomposition:
- Shared package down_timer_pkg with:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_HOLD=2'd2; 2'd3 is illegal and is forced to ST_IDLE.
  - default WIDTH constant.
- No sub-module. Next-state/count logic and the output registers live in one module.

Test Plan:
- Reset: rst=1 for 2 cycles during RUN -> cnt=0, busy=0, done=0 the cycle after the first rst edge.
- One-shot: load 5, start, auto_reload=0 -> cnt 5,4,3,2,1,0 on successive edges. Exactly one done pulse coincides with cnt=0, and busy drops in the same cycle.
- Periodic: load 3, auto_reload=1, start, run 12 cycles -> cnt sequence 3,2,1,3,2,1,... with done pulses every 3 cycles (4 pulses), busy always 1. Then stop -> IDLE, cnt held.
- Hold: load 4, start, assert hold for 3 cycles when cnt=2 -> cnt stays 2 for 3 cycles plus the resume cycle. done occurs 4 cycles later than without hold.
- Boundaries:
  - start with cnt=0 -> single done, busy stays 0.
  - load 15 -> done after 15 decrements, no wrap.
  - stop on the cnt==1 cycle -> no done, cnt=1.
- Priority: assert load=1 (val 7) with start=1 and stop=1 mid-run -> cnt=7, IDLE, no done. The following start counts down from 7.
